// File: rtl/qoi_frame_arbiter_if.sv
// Bundle of the two source pixel streams and the muxed encoder stream.
// master: the arbiter's view (consumes s0/s1, produces m_*).
// slave:  the environment's view (cameras drive s0/s1, encoder sinks m_*).
interface qoi_frame_arbiter_if #(
  parameter int unsigned PW = 24
);
  logic          s0_valid;
  logic          s0_ready;
  logic [PW-1:0] s0_data;
  logic          s0_hlast;
  logic          s0_vlast;

  logic          s1_valid;
  logic          s1_ready;
  logic [PW-1:0] s1_data;
  logic          s1_hlast;
  logic          s1_vlast;

  logic          m_valid;
  logic          m_ready;
  logic [PW-1:0] m_data;
  logic          m_hlast;
  logic          m_last;

  modport master (
    input  s0_valid, s0_data, s0_hlast, s0_vlast,
    input  s1_valid, s1_data, s1_hlast, s1_vlast,
    input  m_ready,
    output s0_ready, s1_ready,
    output m_valid, m_data, m_hlast, m_last
  );

  modport slave (
    output s0_valid, s0_data, s0_hlast, s0_vlast,
    output s1_valid, s1_data, s1_hlast, s1_vlast,
    output m_ready,
    input  s0_ready, s1_ready,
    input  m_valid, m_data, m_hlast, m_last
  );
endinterface

// File: rtl/qoi_frame_arbiter.sv
// Frame-granular arbiter sharing one QOI encoder between two RGB sources.
// A grant lasts from the first beat to the accepted hlast&&vlast beat, and
// one IDLE cycle always separates consecutive frames.
// Optional macro QOI_ARB_FIXED_PRIORITY_EN: source 0 always wins contested
// arbitrations (no priority pointer). Default build is frame round-robin.
module qoi_frame_arbiter #(
  parameter int unsigned PW       = 24,
  parameter int unsigned LGFRAMES = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  qoi_frame_arbiter_if.master bus,
  output logic                o_busy,
  output logic                o_owner,
  output logic [LGFRAMES-1:0] o_frames0,
  output logic [LGFRAMES-1:0] o_frames1
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic [LGFRAMES-1:0] frames0_q, frames1_q;
  logic                frame_end0, frame_end1;
  logic                prefer0;

`ifdef QOI_ARB_FIXED_PRIORITY_EN
  // Source 0 wins every contested arbitration.
  assign prefer0 = 1'b1;
`else
  logic prio_q;

  // Priority pointer: after a frame ends the other source is preferred.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      prio_q <= 1'b0;
    end else if (frame_end0) begin
      prio_q <= 1'b1;
    end else if (frame_end1) begin
      prio_q <= 1'b0;
    end
  end

  assign prefer0 = ~prio_q;
`endif

  // State, owner and completed-frame counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      frames0_q <= '0;
      frames1_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (frame_end0) begin
        frames0_q <= frames0_q + LGFRAMES'(1);
      end
      if (frame_end1) begin
        frames1_q <= frames1_q + LGFRAMES'(1);
      end
    end
  end

  // Grant decision in IDLE, stream pass-through and frame-end detection.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    frame_end0   = 1'b0;
    frame_end1   = 1'b0;
    bus.m_valid  = 1'b0;
    bus.m_data   = {PW{1'b0}};
    bus.m_hlast  = 1'b0;
    bus.m_last   = 1'b0;
    bus.s0_ready = 1'b0;
    bus.s1_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.s0_valid && (!bus.s1_valid || prefer0)) begin
          state_d = GRANT0;
          owner_d = 1'b0;
        end else if (bus.s1_valid) begin
          state_d = GRANT1;
          owner_d = 1'b1;
        end
      end

      GRANT0: begin
        bus.m_valid  = bus.s0_valid;
        bus.m_data   = bus.s0_data;
        bus.m_hlast  = bus.s0_hlast;
        bus.m_last   = bus.s0_hlast && bus.s0_vlast;
        bus.s0_ready = bus.m_ready;
        frame_end0   = bus.s0_valid && bus.m_ready && bus.s0_hlast && bus.s0_vlast;
        if (frame_end0) begin
          state_d = IDLE;
        end
      end

      GRANT1: begin
        bus.m_valid  = bus.s1_valid;
        bus.m_data   = bus.s1_data;
        bus.m_hlast  = bus.s1_hlast;
        bus.m_last   = bus.s1_hlast && bus.s1_vlast;
        bus.s1_ready = bus.m_ready;
        frame_end1   = bus.s1_valid && bus.m_ready && bus.s1_hlast && bus.s1_vlast;
        if (frame_end1) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_busy    = (state_q != IDLE);
  assign o_owner   = owner_q;
  assign o_frames0 = frames0_q;
  assign o_frames1 = frames1_q;

endmodule

// File: tb/tb_qoi_frame_arbiter.sv
// Directed self-checking bench for qoi_frame_arbiter (round-robin build).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_qoi_frame_arbiter;

  logic clk = 1'b0;
  logic i_reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  logic        busy, owner, busy2, owner2;
  logic [15:0] frames0, frames1;
  logic [1:0]  f2_0, f2_1;

  qoi_frame_arbiter_if #(.PW(24)) bus ();
  qoi_frame_arbiter_if #(.PW(24)) bus2 ();

  qoi_frame_arbiter #(.PW(24), .LGFRAMES(16)) dut (
    .i_clk(clk), .i_reset(i_reset), .bus(bus),
    .o_busy(busy), .o_owner(owner), .o_frames0(frames0), .o_frames1(frames1)
  );

  qoi_frame_arbiter #(.PW(24), .LGFRAMES(2)) dut2 (
    .i_clk(clk), .i_reset(i_reset), .bus(bus2),
    .o_busy(busy2), .o_owner(owner2), .o_frames0(f2_0), .o_frames1(f2_1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset;
    @(negedge clk);
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
  endtask

  task automatic test_reset;
    bus.s0_valid = 1'b1; bus.s1_valid = 1'b1; bus.m_ready = 1'b1;
    @(negedge clk); #1;
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%0b exp=0", bus.m_valid); end
    total++; if (bus.s0_ready !== 1'b0 || bus.s1_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b%0b exp=00", bus.s0_ready, bus.s1_ready); end
    total++; if (busy !== 1'b0 || owner !== 1'b0) begin bad++; $display("FAIL rst_busy_owner got=%0b%0b exp=00", busy, owner); end
    total++; if (frames0 !== 16'd0 || frames1 !== 16'd0) begin bad++; $display("FAIL rst_frames got=%0d/%0d exp=0/0", frames0, frames1); end
    bus.s0_valid = 1'b0; bus.s1_valid = 1'b0;
  endtask

  task automatic test_single;
    bus.s0_valid = 1'b0; bus.s1_valid = 1'b0; bus.m_ready = 1'b1;
    do_reset();
    bus.s0_valid = 1'b1; bus.s0_data = 24'h100000; bus.s0_hlast = 1'b0; bus.s0_vlast = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || bus.m_valid !== 1'b0 || bus.s0_ready !== 1'b0) begin bad++; $display("FAIL single_idle got=%0b%0b%0b exp=000", busy, bus.m_valid, bus.s0_ready); end
    total++; if (bus.m_data !== 24'h0) begin bad++; $display("FAIL single_idle_data got=%0h exp=0", bus.m_data); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.s0_data = 24'h100000 | 24'(i); bus.s0_hlast = (i % 4 == 3); bus.s0_vlast = (i >= 4);
      #1;
      total++; if (busy !== 1'b1 || owner !== 1'b0) begin bad++; $display("FAIL single_grant beat=%0d got=%0b%0b exp=10", i, busy, owner); end
      total++; if (bus.m_valid !== 1'b1 || bus.s0_ready !== 1'b1 || bus.s1_ready !== 1'b0) begin bad++; $display("FAIL single_hs beat=%0d got=%0b%0b%0b exp=110", i, bus.m_valid, bus.s0_ready, bus.s1_ready); end
      total++; if (bus.m_data !== (24'h100000 | 24'(i))) begin bad++; $display("FAIL single_data beat=%0d got=%0h exp=%0h", i, bus.m_data, 24'h100000 | 24'(i)); end
      total++; if (bus.m_hlast !== (i % 4 == 3) || bus.m_last !== (i == 7)) begin bad++; $display("FAIL single_last beat=%0d got=%0b%0b exp=%0b%0b", i, bus.m_hlast, bus.m_last, (i % 4 == 3), (i == 7)); end
    end
    @(negedge clk);
    bus.s0_valid = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || owner !== 1'b0) begin bad++; $display("FAIL single_end_state got=%0b%0b exp=00", busy, owner); end
    total++; if (frames0 !== 16'd1 || frames1 !== 16'd0) begin bad++; $display("FAIL single_frames got=%0d/%0d exp=1/0", frames0, frames1); end
  endtask

  task automatic test_contention;
    int       exp_order [4] = '{0, 1, 0, 1};
    int       ends = 0;
    logic [1:0] idx0 = 2'd0, idx1 = 2'd0;
    bit       exp_idle = 1'b1, exp_busy = 1'b0, adv0, adv1;
    logic [23:0] exp_data;
    bus.s0_valid = 1'b1; bus.s1_valid = 1'b1; bus.m_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 100 && ends < 4; c++) begin
      if (c > 0) @(negedge clk);
      bus.s0_data = 24'hA00000 | 24'(idx0); bus.s0_hlast = idx0[0]; bus.s0_vlast = idx0[1];
      bus.s1_data = 24'hB00000 | 24'(idx1); bus.s1_hlast = idx1[0]; bus.s1_vlast = idx1[1];
      #1;
      if (exp_busy) begin
        exp_busy = 1'b0;
        total++; if (busy !== 1'b1 || owner !== 1'(exp_order[ends])) begin bad++; $display("FAIL rr_grant frame=%0d got=%0b%0b exp=1%0d", ends, busy, owner, exp_order[ends]); end
      end
      if (exp_idle) begin
        exp_idle = 1'b0;
        exp_busy = 1'b1;
        total++; if (busy !== 1'b0 || bus.m_valid !== 1'b0) begin bad++; $display("FAIL rr_idle frame=%0d got=%0b%0b exp=00", ends, busy, bus.m_valid); end
      end
      if (bus.m_valid === 1'b1) begin
        exp_data = (owner == 1'b0) ? (24'hA00000 | 24'(idx0)) : (24'hB00000 | 24'(idx1));
        total++; if (bus.m_data !== exp_data) begin bad++; $display("FAIL rr_data got=%0h exp=%0h", bus.m_data, exp_data); end
      end
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1 && bus.m_last === 1'b1) begin
        total++; if (owner !== 1'(exp_order[ends])) begin bad++; $display("FAIL rr_order frame=%0d got=%0b exp=%0d", ends, owner, exp_order[ends]); end
        ends++;
        exp_idle = 1'b1;
      end
      adv0 = bus.s0_valid && bus.s0_ready;
      adv1 = bus.s1_valid && bus.s1_ready;
      @(posedge clk);
      if (adv0) idx0 = idx0 + 2'd1;
      if (adv1) idx1 = idx1 + 2'd1;
    end
    total++; if (ends != 4) begin bad++; $display("FAIL rr_timeout got=%0d exp=4", ends); end
    @(negedge clk);
    bus.s0_valid = 1'b0; bus.s1_valid = 1'b0;
    #1;
    total++; if (frames0 !== 16'd2 || frames1 !== 16'd2) begin bad++; $display("FAIL rr_frames got=%0d/%0d exp=2/2", frames0, frames1); end
  endtask

  task automatic test_backpressure;
    int   idx = 0;
    bit   prev_stall = 1'b0;
    logic [23:0] held = 24'h0;
    bus.s0_valid = 1'b0; bus.s1_valid = 1'b0; bus.m_ready = 1'b1;
    do_reset();
    bus.s0_valid = 1'b1; bus.s0_data = 24'h0; bus.s0_hlast = 1'b0; bus.s0_vlast = 1'b0;
    bus.s0_valid = 1'b0;
    bus.s1_valid = 1'b1; bus.s1_data = 24'h700000; bus.s1_hlast = 1'b0; bus.s1_vlast = 1'b1;
    for (int c = 0; c < 20 && idx < 3; c++) begin
      @(negedge clk);
      bus.m_ready = (c % 2 == 0);
      bus.s1_data = 24'h700000 | 24'(idx); bus.s1_hlast = (idx == 2);
      #1;
      total++; if (bus.s1_ready !== bus.m_ready || bus.s0_ready !== 1'b0) begin bad++; $display("FAIL bp_ready cyc=%0d got=%0b%0b exp=%0b0", c, bus.s1_ready, bus.s0_ready, bus.m_ready); end
      total++; if (bus.m_data !== (24'h700000 | 24'(idx)) || owner !== 1'b1) begin bad++; $display("FAIL bp_data cyc=%0d got=%0h exp=%0h", c, bus.m_data, 24'h700000 | 24'(idx)); end
      if (prev_stall) begin
        total++; if (bus.m_data !== held) begin bad++; $display("FAIL bp_hold cyc=%0d got=%0h exp=%0h", c, bus.m_data, held); end
      end
      prev_stall = !bus.m_ready;
      held = bus.m_data;
      if (bus.m_ready) idx++;
    end
    @(negedge clk);
    bus.m_ready = 1'b1; bus.s1_valid = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || frames1 !== 16'd1 || frames0 !== 16'd0) begin bad++; $display("FAIL bp_end got=%0b %0d/%0d exp=0 0/1", busy, frames0, frames1); end
  endtask

  task automatic test_stall;
    bus.s0_valid = 1'b0; bus.s1_valid = 1'b0; bus.m_ready = 1'b1;
    do_reset();
    bus.s1_valid = 1'b1; bus.s1_data = 24'h5A5A5A; bus.s1_hlast = 1'b1; bus.s1_vlast = 1'b1;
    bus.s0_valid = 1'b1; bus.s0_data = 24'h300000; bus.s0_hlast = 1'b0; bus.s0_vlast = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          bus.s0_valid = 1'b0;
          #1;
          total++; if (busy !== 1'b1 || owner !== 1'b0 || bus.m_valid !== 1'b0 || bus.s1_ready !== 1'b0) begin bad++; $display("FAIL stall_hold cyc=%0d got=%0b%0b%0b%0b exp=1000", s, busy, owner, bus.m_valid, bus.s1_ready); end
        end
        bus.s0_valid = 1'b1;
      end
      @(negedge clk);
      bus.s0_data = 24'h300000 | 24'(i); bus.s0_hlast = (i % 2 == 1); bus.s0_vlast = (i >= 4);
      #1;
      total++; if (owner !== 1'b0 || bus.s0_ready !== 1'b1 || bus.s1_ready !== 1'b0) begin bad++; $display("FAIL stall_grant beat=%0d got=%0b%0b%0b exp=010", i, owner, bus.s0_ready, bus.s1_ready); end
      total++; if (bus.m_data !== (24'h300000 | 24'(i)) || bus.m_last !== (i == 5)) begin bad++; $display("FAIL stall_beat beat=%0d got=%0h/%0b exp=%0h/%0b", i, bus.m_data, bus.m_last, 24'h300000 | 24'(i), (i == 5)); end
    end
    @(negedge clk);
    bus.s0_valid = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || frames0 !== 16'd1) begin bad++; $display("FAIL stall_release got=%0b/%0d exp=0/1", busy, frames0); end
    @(negedge clk); #1;
    total++; if (busy !== 1'b1 || owner !== 1'b1 || bus.s1_ready !== 1'b1) begin bad++; $display("FAIL stall_next got=%0b%0b%0b exp=111", busy, owner, bus.s1_ready); end
  endtask

  task automatic test_mid_reset;
    @(negedge clk);
    bus.s1_valid = 1'b0; bus.m_ready = 1'b1;
    bus.s0_valid = 1'b1; bus.s0_data = 24'h900000; bus.s0_hlast = 1'b0; bus.s0_vlast = 1'b0;
    #1;
    total++; if (frames0 !== 16'd1 || frames1 !== 16'd1) begin bad++; $display("FAIL mr_pre got=%0d/%0d exp=1/1", frames0, frames1); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.s0_data = 24'h900000 | 24'(i); bus.s0_hlast = 1'b0;
    end
    #1;
    total++; if (busy !== 1'b1 || bus.m_data !== 24'h900003) begin bad++; $display("FAIL mr_mid got=%0b/%0h exp=1/900003", busy, bus.m_data); end
    #1 i_reset = 1'b1;
    #1;
    total++; if (bus.m_valid !== 1'b0 || bus.s0_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mr_async got=%0b%0b%0b exp=000", bus.m_valid, bus.s0_ready, busy); end
    total++; if (frames0 !== 16'd0 || frames1 !== 16'd0) begin bad++; $display("FAIL mr_frames got=%0d/%0d exp=0/0", frames0, frames1); end
    @(negedge clk);
    i_reset = 1'b0;
    bus.s0_data = 24'h900000;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mr_idle got=%0b exp=0", busy); end
    @(negedge clk); #1;
    total++; if (busy !== 1'b1 || owner !== 1'b0 || bus.m_valid !== 1'b1 || bus.m_data !== 24'h900000) begin bad++; $display("FAIL mr_regrant got=%0b%0b%0b/%0h exp=101/900000", busy, owner, bus.m_valid, bus.m_data); end
    bus.s0_valid = 1'b0;
  endtask

  task automatic test_wrap;
    logic [1:0] exp_f [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    int nf = 0;
    bit chk = 1'b0;
    bus2.s1_valid = 1'b0; bus2.m_ready = 1'b1;
    do_reset();
    bus2.s1_valid = 1'b1; bus2.s1_data = 24'hC0FFEE; bus2.s1_hlast = 1'b1; bus2.s1_vlast = 1'b1;
    for (int c = 0; c < 40 && nf < 5; c++) begin
      @(negedge clk); #1;
      if (chk) begin
        chk = 1'b0;
        total++; if (f2_1 !== exp_f[nf]) begin bad++; $display("FAIL wrap_count frame=%0d got=%0d exp=%0d", nf, f2_1, exp_f[nf]); end
        nf++;
      end
      if (nf < 5 && bus2.m_valid === 1'b1 && bus2.m_ready === 1'b1 && bus2.m_last === 1'b1) chk = 1'b1;
    end
    total++; if (nf != 5) begin bad++; $display("FAIL wrap_timeout got=%0d exp=5", nf); end
    bus2.s1_valid = 1'b0;
  endtask

  initial begin
    bus.s0_valid = 1'b0; bus.s0_data = '0; bus.s0_hlast = 1'b0; bus.s0_vlast = 1'b0;
    bus.s1_valid = 1'b0; bus.s1_data = '0; bus.s1_hlast = 1'b0; bus.s1_vlast = 1'b0;
    bus.m_ready = 1'b0;
    bus2.s0_valid = 1'b0; bus2.s0_data = '0; bus2.s0_hlast = 1'b0; bus2.s0_vlast = 1'b0;
    bus2.s1_valid = 1'b0; bus2.s1_data = '0; bus2.s1_hlast = 1'b0; bus2.s1_vlast = 1'b0;
    bus2.m_ready = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_stall();
    test_mid_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qoi_frame_arbiter.md
Name: qoi_frame_arbiter

Overview:
- Shares one QOI encoder between two independent 24-bit RGB video sources.
- Grants the encoder input to one source for a whole frame at a time. Switches only at frame end (hlast && vlast accepted), so each compressed QOI stream contains exactly one uninterrupted frame.
- Sits between the two camera/video pipelines and the encoder's s_* port.
- Reports which source owns the current frame and keeps per-source completed-frame counts.

Parameters:
- PW, 24, pixel data width.
- LGFRAMES, 16, width of each per-source completed-frame counter.

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  asynchronous, active-high reset
- s0_valid  input  1  source 0 pixel valid
- s0_ready  output  1  source 0 pixel accepted
- s0_data  input  PW  source 0 pixel
- s0_hlast  input  1  source 0 last pixel of line
- s0_vlast  input  1  source 0 last line of frame
- s1_valid, s1_ready, s1_data, s1_hlast, s1_vlast: same as source 0, for source 1
- m_valid  output  1  pixel valid to encoder
- m_ready  input  1  encoder ready
- m_data  output  PW  muxed pixel
- m_hlast  output  1  muxed hlast (drives encoder s_user)
- m_last  output  1  m_hlast && m_vlast of granted source (drives encoder s_last)
- o_busy  output  1  a frame grant is active
- o_owner  output  1  source owning current/most recent grant
- o_frames0  output  LGFRAMES  frames completed by source 0
- o_frames1  output  LGFRAMES  frames completed by source 1

Behaviour:
- Reset (async assert, sync release): state IDLE, o_busy=0, o_owner=0, priority pointer=0 (source 0 preferred), o_frames0=o_frames1=0. All readies and m_valid are 0 while reset is asserted.
- States: IDLE, GRANT0, GRANT1.
- IDLE:
  - m_valid=0, s0_ready=s1_ready=0.
  - Only s0_valid: next state GRANT0. Only s1_valid: next state GRANT1.
  - Both valid: grant the source named by the priority pointer.
  - Grant decision is registered, so the first beat can pass on the cycle after the request is seen. Minimum grant latency is 1 cycle.
- GRANTx:
  - Combinational pass-through: m_valid=sx_valid, m_data=sx_data, m_hlast=sx_hlast, m_last=sx_hlast&&sx_vlast, sx_ready=m_ready.
  - Non-granted source ready=0 and must hold its data (AXI-stream rules).
  - o_busy=1, o_owner=x.
- Frame end: a beat accepted (m_valid && m_ready) with m_last=1 does all of the following on that clock edge:
  - state goes to IDLE
  - o_framesx increments; wraps modulo 2^LGFRAMES with no saturation
  - priority pointer is set to the other source
- One dead cycle (IDLE) always separates frames, even back-to-back frames from the same source.
- hlast without vlast does not release the grant. Line boundaries are ignored by the arbiter.
- Granted source dropping valid mid-frame: grant is held indefinitely, m_valid=0, and the other source stays stalled. There is no timeout.
- m_data/m_hlast/m_last are don't-care while m_valid=0. They are still driven from the granted source; in IDLE they are driven to 0.
- Reset asserted mid-frame: immediate return to IDLE with counters cleared. The encoder shares i_reset, so no partial frame survives.
- o_owner holds its last value in IDLE.

Optional Feature:
- Macro QOI_ARB_FIXED_PRIORITY_EN.
- Defined: source 0 always wins when both sources request in IDLE. The priority pointer is removed, and source 1 can starve.
- Undefined (default): round-robin at frame granularity as above. Neither source can win two consecutive contested arbitrations.

Test Plan:
- Single source: s0 sends a 4x2 frame with m_ready=1 and s1 idle. Required: GRANT0 one cycle after s0_valid; 8 beats pass unaltered; m_last only on beat 8; then IDLE; o_frames0=1, o_frames1=0.
- Contention, round-robin: s0 and s1 both valid from reset, each sending 2x2 frames continuously. Required: grant order 0,1,0,1; exactly one idle cycle between frames; after 4 frames o_frames0=2, o_frames1=2.
- Backpressure: m_ready toggles 1,0,1,0 during an s1 3x1 frame. Required: s1_ready mirrors m_ready; s0_ready=0 throughout; m_data stable while m_ready=0; frame completes with o_frames1=1.
- Line boundary and mid-frame stall: s0 asserts hlast at pixel 2 of a 2x3 frame, then drops valid for 5 cycles while s1 is valid. Required: grant stays 0; s1_ready=0; grant releases only after beat 6 (hlast && vlast).
- Reset mid-frame: assert i_reset after beat 3 of an s0 frame. Required: asynchronously m_valid=0, s0_ready=0, o_busy=0, counters 0; after release, the first request is granted normally.
- Counter wrap: LGFRAMES=2, s1 sends five 1x1 frames. Required: o_frames1 sequence 1,2,3,0,1.
